// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: arbiter state encoding and Wishbone width constants
package wb_arbiter_pkg;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TIMEOUT, ST_RELEASE} state_t;
endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// wb_arbiter_rr_pick: combinational round-robin select, first requester after i_last
module wb_arbiter_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_k;
  always_comb begin
    o_idx = '0;
    w_k = '0;
    for (int i = N; i >= 1; i--) begin
      w_k = IW'((int'(i_last) + i) % N);
      if (i_req[w_k]) o_idx = w_k;
    end
    o_valid = |i_req;
    o_gnt = o_valid ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 classic arbiter with slave watchdog
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       m_rty_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);
  localparam int N  = NUM_MASTERS;
  localparam int IW = $clog2(N);
  localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t        r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_last;
  logic [WW-1:0] r_wd;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_valid;
  logic          w_act;
  logic          w_term;
  logic          w_wd_hit;
  wb_arbiter_rr_pick #(.N(N)) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );
  assign w_act    = r_state == ST_GRANT;
  assign w_term   = s_ack_i | s_err_i | s_rty_i;
  assign w_wd_hit = TIMEOUT_CYCLES != 0 && r_wd == WW'(TIMEOUT_CYCLES - 1);
  assign s_cyc_o   = w_act & m_cyc_i[r_idx];
  assign s_stb_o   = w_act & m_stb_i[r_idx];
  assign s_we_o    = m_we_i[r_idx];
  assign s_adr_o   = m_adr_i[ADR_W*r_idx +: ADR_W];
  assign s_dat_o   = m_dat_i[DAT_W*r_idx +: DAT_W];
  assign s_sel_o   = m_sel_i[SEL_W*r_idx +: SEL_W];
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = w_act & s_ack_i ? r_grant : '0;
  assign m_err_o   = (w_act & s_err_i) | (r_state == ST_TIMEOUT) ? r_grant : '0;
  assign m_rty_o   = w_act & s_rty_i ? r_grant : '0;
  assign grant_o   = r_grant;
  assign timeout_o = r_state == ST_TIMEOUT;
  // watchdog falls back to zero on every path that does not explicitly hold or advance it
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= IW'(N - 1);
      r_wd    <= '0;
    end else begin
      r_wd <= '0;
      case (r_state)
        ST_IDLE: if (w_valid) begin
          r_state <= ST_GRANT;
          r_grant <= w_gnt;
          r_idx   <= w_idx;
          r_last  <= w_idx;
        end
        ST_GRANT: if (!m_cyc_i[r_idx]) begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end else if (!w_term && m_stb_i[r_idx] && w_wd_hit) r_state <= ST_TIMEOUT;
        else if (!w_term) r_wd <= m_stb_i[r_idx] && r_wd != '1 ? r_wd + 1'b1 : r_wd;
        ST_TIMEOUT: r_state <= ST_RELEASE;
        default: if (!m_cyc_i[r_idx]) begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (2 masters, 4-cycle watchdog)
module tb_wb_arbiter;
  localparam int N = 2;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
  logic [31:0]  a0, a1, d0, d1, m_dat, s_adr, s_dat, s_dat_i;
  logic [3:0]   sel0, sel1, s_sel;
  logic         s_cyc, s_stb, s_we, s_ack, s_err, s_rty, timeout;
  logic [1:0]   g;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(4)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   ({a1, a0}),
    .m_dat_i   ({d1, d0}),
    .m_sel_i   ({sel1, sel0}),
    .m_dat_o   (m_dat),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_rty_o   (m_rty),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_sel_o   (s_sel),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .s_rty_i   (s_rty),
    .grant_o   (grant),
    .timeout_o (timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    #2 rst_n = 1'b1;
    #1;
  endtask
  initial begin
    a0 = 32'hA000_0010; a1 = 32'hB100_0020;
    d0 = 32'hD0D0_0000; d1 = 32'hD1D1_1111;
    sel0 = 4'h3; sel1 = 4'hC; s_dat_i = 32'h5A5A_1234;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_tmo", timeout, 0);
    #2 rst_n = 1'b1;
    tick; m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; #1;
    chk("lat_idle_grant", grant, 0);
    chk("lat_idle_scyc", s_cyc, 0);
    tick; #1;
    chk("t1_grant", grant, 2'b01);
    chk("t1_scyc", s_cyc, 1);
    chk("t1_adr", s_adr, a0);
    chk("t1_dat", s_dat, d0);
    chk("t1_sel", s_sel, sel0);
    chk("t1_we", s_we, 1);
    chk("t1_ack_wait", m_ack, 0);
    tick; s_ack = 1'b1; #1;
    chk("t1_ack", m_ack, 2'b01);
    chk("t1_mdat", m_dat, s_dat_i);
    tick; s_ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
    chk("t1_ack_once", m_ack, 0);
    chk("t1_drop_scyc", s_cyc, 0);
    tick; #1;
    chk("t1_idle", grant, 0);
    do_reset;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int r = 0; r < 4; r++) begin
      g = r[0] ? 2'b10 : 2'b01;
      tick; #1;
      chk("rr_grant", grant, g);
      chk("rr_adr", s_adr, g == 2'b01 ? a0 : a1);
      s_ack = 1'b1; #1;
      chk("rr_ack", m_ack, g);
      tick; s_ack = 1'b0; m_cyc = ~g; m_stb = ~g; #1;
      chk("rr_ack_clear", m_ack, 0);
      tick; m_cyc = 2'b11; m_stb = 2'b11; #1;
      chk("rr_idle", grant, 0);
    end
    do_reset;
    m_cyc = 2'b01; m_stb = 2'b01;
    tick; m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    repeat (3) begin
      #1;
      chk("blk_ack0", m_ack, 2'b01);
      chk("blk_hold", grant, 2'b01);
      tick;
    end
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10; #1;
    chk("blk_drop_grant", grant, 2'b01);
    chk("blk_drop_scyc", s_cyc, 0);
    tick; #1;
    chk("blk_idle_gap", grant, 0);
    tick; #1;
    chk("blk_grant1", grant, 2'b10);
    chk("blk_adr1", s_adr, a1);
    chk("blk_sel1", s_sel, sel1);
    do_reset;
    m_cyc = 2'b01; m_stb = 2'b01;
    tick;
    repeat (4) begin
      #1;
      chk("wd_no_tmo", timeout, 0);
      chk("wd_scyc", s_cyc, 1);
      tick;
    end
    s_ack = 1'b1; #1;
    chk("wd_tmo", timeout, 1);
    chk("wd_err", m_err, 2'b01);
    chk("wd_ack_drop", m_ack, 0);
    chk("wd_scyc_low", s_cyc, 0);
    chk("wd_sstb_low", s_stb, 0);
    chk("wd_grant", grant, 2'b01);
    tick; s_ack = 1'b0; #1;
    chk("rel_tmo", timeout, 0);
    chk("rel_err", m_err, 0);
    chk("rel_scyc", s_cyc, 0);
    chk("rel_grant", grant, 2'b01);
    tick; m_cyc = '0; m_stb = '0; #1;
    chk("rel_hold", grant, 2'b01);
    tick; #1;
    chk("rel_idle", grant, 0);
    do_reset;
    m_cyc = 2'b10; m_stb = 2'b10;
    tick; tick; tick; s_err = 1'b1; #1;
    chk("err_fwd", m_err, 2'b10);
    chk("err_ack", m_ack, 0);
    chk("err_tmo", timeout, 0);
    tick; s_err = 1'b0;
    repeat (3) begin
      #1;
      chk("err_wd_clr", s_cyc, 1);
      tick;
    end
    s_rty = 1'b1; #1;
    chk("rty_fwd", m_rty, 2'b10);
    chk("rty_err", m_err, 0);
    tick; s_rty = 1'b0; #1;
    chk("rty_wd_clr", timeout, 0);
    chk("rty_scyc", s_cyc, 1);
    tick; #1;
    chk("rty_wd_clr2", timeout, 0);
    m_cyc = '0; m_stb = '0;
    do_reset;
    m_cyc = 2'b01; m_stb = 2'b01;
    tick; s_ack = 1'b1; #1;
    chk("ar_pre_ack", m_ack, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_scyc", s_cyc, 0);
    chk("ar_grant", grant, 0);
    chk("ar_ack", m_ack, 0);
    #1 rst_n = 1'b1; s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    tick; #1;
    chk("ar_first_grant", grant, 2'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
